// File: rtl/iic_pkg.sv
// Shared types and helpers for the burst I2C master.
// Holds the FSM state encoding and the quarter divider math.
package iic_pkg;

  typedef enum logic [3:0] {
    s_idle,
    s_start,
    s_addr,
    s_addr_ack,
    s_wr_byte,
    s_wr_ack,
    s_rd_byte,
    s_rd_ack,
    s_stop
  } state_t;

  typedef logic [1:0] quarter_t;

  function automatic int iic_div(
    input int clk_hz,
    input int scl_hz
  );
    int d;
    d = clk_hz / (4 * scl_hz);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/iic_quarter_tick.sv
// Quarter-bit divider for the I2C master.
// Freezes while a slave stretches SCL, restarts from q0 on clr.
module iic_quarter_tick
  import iic_pkg::*;
#(
  parameter int DIV = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] q
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = !clr && !hold && (cnt == CW'(DIV - 1));

  // divider count and quarter index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= '0;
    end else if (clr) begin
      cnt <= '0;
      q   <= '0;
    end else if (!hold) begin
      if (tick) begin
        cnt <= '0;
        q   <= q + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iic_master_burst.sv
// I2C master: START, 7-bit address, 0..MAX_LEN byte burst, STOP.
// Supports reads with master ACK/NACK, slave NACK and SCL stretching.
module iic_master_burst
  import iic_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int IIC_FREQ = 400_000,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       dev_addr,
  input  logic             rw,
  input  logic [LEN_W-1:0] len,
  output logic             wr_req,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             scl_oe,
  input  logic             scl_i,
  output logic             sda_oe,
  input  logic             sda_i
);

  localparam int DIV = iic_div(CLK_FREQ, IIC_FREQ);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  state_t           state, state_n;
  logic             tick;
  logic             hold;
  logic             clr;
  logic [1:0]       q;
  logic [7:0]       sh;
  logic [2:0]       bcnt;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] len_sat;
  logic             rw_r;
  logic             samp;
  logic             end_bit;
  logic             smp;
  logic             tx_bit;

  assign end_bit = tick && (q == 2'd3);
  assign smp     = tick && (q == 2'd2);
  assign clr     = (state == s_idle);
  assign hold    = q[1] && !scl_oe && !scl_i;
  assign busy    = (state != s_idle);
  assign len_sat = (len > LMAX) ? LMAX : len;
  assign tx_bit  = wr_req ? wr_data[7] : sh[7];

  iic_quarter_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .hold  (hold),
    .tick  (tick),
    .q     (q)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= s_idle;
    else        state <= state_n;
  end

  // next state and bus drive
  always_comb begin
    state_n = state;
    scl_oe  = 1'b0;
    sda_oe  = 1'b0;
    case (state)
      s_idle: begin
        if (start) state_n = s_start;
      end
      s_start: begin
        sda_oe = q[1];
        scl_oe = (q == 2'd3);
        if (end_bit) state_n = s_addr;
      end
      s_addr: begin
        scl_oe = !q[1];
        sda_oe = !tx_bit;
        if (end_bit && bcnt == 3'd0)
          state_n = s_addr_ack;
      end
      s_addr_ack: begin
        scl_oe = !q[1];
        if (end_bit) begin
          if (samp)           state_n = s_stop;
          else if (rem == '0) state_n = s_stop;
          else if (!rw_r)     state_n = s_wr_byte;
          else                state_n = s_rd_byte;
        end
      end
      s_wr_byte: begin
        scl_oe = !q[1];
        sda_oe = !tx_bit;
        if (end_bit && bcnt == 3'd0)
          state_n = s_wr_ack;
      end
      s_wr_ack: begin
        scl_oe = !q[1];
        if (end_bit) begin
          if (samp)           state_n = s_stop;
          else if (rem > ONE) state_n = s_wr_byte;
          else                state_n = s_stop;
        end
      end
      s_rd_byte: begin
        scl_oe = !q[1];
        if (end_bit && bcnt == 3'd0)
          state_n = s_rd_ack;
      end
      s_rd_ack: begin
        scl_oe = !q[1];
        sda_oe = (rem > ONE);
        if (end_bit) begin
          if (rem > ONE) state_n = s_rd_byte;
          else           state_n = s_stop;
        end
      end
      s_stop: begin
        scl_oe = (q == 2'd0);
        sda_oe = (q != 2'd3);
        if (end_bit) state_n = s_idle;
      end
      default: state_n = s_idle;
    endcase
  end

  // shift register, counters and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      rd_data  <= 8'h00;
      sh       <= 8'h00;
      bcnt     <= 3'd0;
      rem      <= '0;
      rw_r     <= 1'b0;
      samp     <= 1'b0;
    end else begin
      wr_req   <= (state_n == s_wr_byte) &&
                  (state != s_wr_byte);
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (smp) samp <= sda_i;
      if (wr_req) sh <= wr_data;
      case (state)
        s_idle: begin
          if (start) begin
            sh   <= {dev_addr, rw};
            rw_r <= rw;
            rem  <= len_sat;
            nack <= 1'b0;
            bcnt <= 3'd7;
          end
        end
        s_addr, s_wr_byte: begin
          if (end_bit) begin
            sh   <= {sh[6:0], 1'b0};
            bcnt <= bcnt - 3'd1;
          end
        end
        s_addr_ack: begin
          if (end_bit && samp) nack <= 1'b1;
        end
        s_wr_ack: begin
          if (end_bit) begin
            if (samp)           nack <= 1'b1;
            else if (rem > ONE) rem  <= rem - ONE;
          end
        end
        s_rd_byte: begin
          if (smp) begin
            sh <= {sh[6:0], sda_i};
            if (bcnt == 3'd0) begin
              rd_data  <= {sh[6:0], sda_i};
              rd_valid <= 1'b1;
            end
          end
          if (end_bit) bcnt <= bcnt - 3'd1;
        end
        s_rd_ack: begin
          if (end_bit && rem > ONE) rem <= rem - ONE;
        end
        s_stop: begin
          if (end_bit) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_master_burst.sv
// Directed bench for iic_master_burst with a bus-level slave model.
// Slave ACKs, returns read data, NACKs on request and stretches SCL.
module tb_iic_master_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic       rw = 1'b0;
  logic [4:0] len = '0;
  logic       wr_req;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl_oe;
  logic       scl_i;
  logic       sda_oe;
  logic       sda_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] wbytes [8];
  logic [2:0] wr_idx = '0;

  logic       present = 1'b1;
  int         nack_idx = 0;
  logic       stretch_en = 1'b0;
  logic [7:0] rdb [$];

  logic       hold = 1'b0;
  int         hold_cnt = 0;
  logic       stretched = 1'b0;
  logic       sl_sda = 1'b0;
  logic       ps = 1'b1;
  logic       pd = 1'b1;
  logic       bscl;
  logic       bsda;
  logic       in_txn = 1'b0;
  logic       rdm = 1'b0;
  int         bitn = 0;
  int         nb = 0;
  logic [7:0] cur = '0;
  logic [7:0] tmp;
  logic [7:0] byte_log [$];
  logic       ack_log [$];
  logic [7:0] rd_log [$];
  int         n_stop = 0;
  int         n_wr = 0;
  int         n_done = 0;

  assign scl_i   = ~scl_oe & ~hold;
  assign sda_i   = ~sda_oe & ~sl_sda;
  assign wr_data = wbytes[wr_idx];

  iic_master_burst dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dev_addr (dev_addr),
    .rw       (rw),
    .len      (len),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .done     (done),
    .nack     (nack),
    .scl_oe   (scl_oe),
    .scl_i    (scl_i),
    .sda_oe   (sda_oe),
    .sda_i    (sda_i)
  );

  always #5 clk = ~clk;

  // show-ahead write source
  always @(posedge clk) begin
    if (start && !busy) wr_idx <= '0;
    else if (wr_req)    wr_idx <= wr_idx + 3'd1;
  end

  // bus monitor and slave model
  always @(negedge clk) begin
    if (wr_req) n_wr++;
    if (done) n_done++;
    if (rd_valid) rd_log.push_back(rd_data);
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) hold = 1'b0;
    end
    if (stretch_en && !stretched && in_txn &&
        bitn == 8 && nb == 0 && !ps && !scl_oe) begin
      hold = 1'b1;
      hold_cnt = 500;
      stretched = 1'b1;
    end
    bscl = ~scl_oe & ~hold;
    bsda = ~sda_oe & ~sl_sda;
    if (ps && bscl && pd && !bsda) begin
      in_txn = 1'b1;
      bitn = 0;
      nb = 0;
      rdm = 1'b0;
      stretched = 1'b0;
    end else if (ps && bscl && !pd && bsda) begin
      n_stop++;
      in_txn = 1'b0;
      sl_sda = 1'b0;
    end else if (!ps && bscl && in_txn) begin
      if (bitn < 8) begin
        cur = {cur[6:0], bsda};
        bitn++;
      end else begin
        byte_log.push_back(cur);
        ack_log.push_back(bsda);
        if (nb == 0) rdm = cur[0] && !bsda;
        else if (rdm && bsda) rdm = 1'b0;
        nb++;
        bitn = 0;
      end
    end else if (ps && !bscl && in_txn) begin
      if (bitn == 8) begin
        sl_sda = present && !rdm &&
                 (nb == 0 || nb != nack_idx);
      end else if (rdm && nb >= 1 && nb <= rdb.size()) begin
        tmp = rdb[nb-1] << bitn;
        sl_sda = ~tmp[7];
      end else begin
        sl_sda = 1'b0;
      end
    end
    ps = bscl;
    pd = bsda;
  end

  task automatic go(input logic [6:0] a, input logic r,
                    input logic [4:0] l, output int cyc);
    @(negedge clk);
    dev_addr = a;
    rw = r;
    len = l;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({scl_oe, sda_oe, busy, done, wr_req,
         rd_valid, nack} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0",
        {scl_oe, sda_oe, busy, done, wr_req, rd_valid, nack});
    end
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd_data got %h want 00", rd_data);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write;
    int cyc, b0, w0, s0;
    present = 1'b1;
    wbytes[0] = 8'hA5;
    wbytes[1] = 8'h3C;
    b0 = byte_log.size();
    w0 = n_wr;
    s0 = n_stop;
    go(7'h3C, 1'b0, 5'd2, cyc);
    checks++;
    if (cyc !== 3596) begin
      errors++;
      $display("FAIL wr_cycles got %0d want 3596", cyc);
    end
    checks++;
    if (nack !== 1'b0) begin
      errors++;
      $display("FAIL wr_nack got %b want 0", nack);
    end
    checks++;
    if (n_wr - w0 !== 2) begin
      errors++;
      $display("FAIL wr_req_cnt got %0d want 2", n_wr - w0);
    end
    checks++;
    if (byte_log.size() - b0 !== 3) begin
      errors++;
      $display("FAIL wr_nbytes got %0d want 3",
        byte_log.size() - b0);
    end else begin
      checks++;
      if ({byte_log[b0], byte_log[b0+1], byte_log[b0+2]}
          !== 24'h78A53C) begin
        errors++;
        $display("FAIL wr_bus got %h%h%h want 78a53c",
          byte_log[b0], byte_log[b0+1], byte_log[b0+2]);
      end
      checks++;
      if ({ack_log[b0], ack_log[b0+1], ack_log[b0+2]}
          !== 3'b000) begin
        errors++;
        $display("FAIL wr_acks got %b%b%b want 000",
          ack_log[b0], ack_log[b0+1], ack_log[b0+2]);
      end
    end
    checks++;
    if (n_stop - s0 !== 1) begin
      errors++;
      $display("FAIL wr_stop got %0d want 1", n_stop - s0);
    end
  endtask

  task automatic test_read;
    int cyc, b0, r0, s0;
    present = 1'b1;
    rdb = '{8'h11, 8'h22, 8'h33};
    b0 = byte_log.size();
    r0 = rd_log.size();
    s0 = n_stop;
    go(7'h50, 1'b1, 5'd3, cyc);
    checks++;
    if (cyc !== 4712) begin
      errors++;
      $display("FAIL rd_cycles got %0d want 4712", cyc);
    end
    checks++;
    if (rd_log.size() - r0 !== 3) begin
      errors++;
      $display("FAIL rd_valid_cnt got %0d want 3",
        rd_log.size() - r0);
    end else begin
      checks++;
      if ({rd_log[r0], rd_log[r0+1], rd_log[r0+2]}
          !== 24'h112233) begin
        errors++;
        $display("FAIL rd_data got %h%h%h want 112233",
          rd_log[r0], rd_log[r0+1], rd_log[r0+2]);
      end
    end
    checks++;
    if (byte_log.size() - b0 !== 4) begin
      errors++;
      $display("FAIL rd_nbytes got %0d want 4",
        byte_log.size() - b0);
    end else begin
      checks++;
      if (byte_log[b0] !== 8'hA1 || ack_log[b0] !== 1'b0) begin
        errors++;
        $display("FAIL rd_addr got %h/%b want a1/0",
          byte_log[b0], ack_log[b0]);
      end
      checks++;
      if ({ack_log[b0+1], ack_log[b0+2], ack_log[b0+3]}
          !== 3'b001) begin
        errors++;
        $display("FAIL rd_master_ack got %b%b%b want 001",
          ack_log[b0+1], ack_log[b0+2], ack_log[b0+3]);
      end
    end
    checks++;
    if (n_stop - s0 !== 1 || nack !== 1'b0) begin
      errors++;
      $display("FAIL rd_stop got %0d/%b want 1/0",
        n_stop - s0, nack);
    end
    rdb = {};
  endtask

  task automatic test_probe;
    int cyc, b0, w0, s0;
    present = 1'b0;
    b0 = byte_log.size();
    w0 = n_wr;
    s0 = n_stop;
    go(7'h27, 1'b0, 5'd0, cyc);
    checks++;
    if (cyc !== 1364) begin
      errors++;
      $display("FAIL probe_cycles got %0d want 1364", cyc);
    end
    checks++;
    if (nack !== 1'b1) begin
      errors++;
      $display("FAIL probe_nack got %b want 1", nack);
    end
    checks++;
    if (n_wr - w0 !== 0) begin
      errors++;
      $display("FAIL probe_wr_req got %0d want 0", n_wr - w0);
    end
    checks++;
    if (n_stop - s0 !== 1) begin
      errors++;
      $display("FAIL probe_stop got %0d want 1", n_stop - s0);
    end
    checks++;
    if (byte_log.size() - b0 !== 1) begin
      errors++;
      $display("FAIL probe_nbytes got %0d want 1",
        byte_log.size() - b0);
    end else if (byte_log[b0] !== 8'h4E ||
                 ack_log[b0] !== 1'b1) begin
      errors++;
      $display("FAIL probe_bus got %h/%b want 4e/1",
        byte_log[b0], ack_log[b0]);
    end
    present = 1'b1;
  endtask

  task automatic test_wr_nack;
    int cyc, b0, w0, s0;
    present = 1'b1;
    nack_idx = 1;
    wbytes[0] = 8'hC1;
    wbytes[1] = 8'hC2;
    wbytes[2] = 8'hC3;
    wbytes[3] = 8'hC4;
    b0 = byte_log.size();
    w0 = n_wr;
    s0 = n_stop;
    go(7'h3C, 1'b0, 5'd4, cyc);
    checks++;
    if (cyc !== 2480) begin
      errors++;
      $display("FAIL nk_cycles got %0d want 2480", cyc);
    end
    checks++;
    if (n_wr - w0 !== 1) begin
      errors++;
      $display("FAIL nk_wr_req got %0d want 1", n_wr - w0);
    end
    checks++;
    if (nack !== 1'b1) begin
      errors++;
      $display("FAIL nk_nack got %b want 1", nack);
    end
    checks++;
    if (byte_log.size() - b0 !== 2) begin
      errors++;
      $display("FAIL nk_nbytes got %0d want 2",
        byte_log.size() - b0);
    end else if (byte_log[b0+1] !== 8'hC1 ||
                 ack_log[b0+1] !== 1'b1) begin
      errors++;
      $display("FAIL nk_bus got %h/%b want c1/1",
        byte_log[b0+1], ack_log[b0+1]);
    end
    checks++;
    if (n_stop - s0 !== 1) begin
      errors++;
      $display("FAIL nk_stop got %0d want 1", n_stop - s0);
    end
    nack_idx = 0;
  endtask

  task automatic test_stretch;
    int cyc, b0;
    present = 1'b1;
    stretch_en = 1'b1;
    wbytes[0] = 8'hA5;
    wbytes[1] = 8'h3C;
    b0 = byte_log.size();
    go(7'h3C, 1'b0, 5'd2, cyc);
    checks++;
    if (cyc !== 4096) begin
      errors++;
      $display("FAIL st_cycles got %0d want 4096", cyc);
    end
    checks++;
    if (byte_log.size() - b0 !== 3) begin
      errors++;
      $display("FAIL st_nbytes got %0d want 3",
        byte_log.size() - b0);
    end else if ({byte_log[b0], byte_log[b0+1],
                  byte_log[b0+2]} !== 24'h78A53C) begin
      errors++;
      $display("FAIL st_bus got %h%h%h want 78a53c",
        byte_log[b0], byte_log[b0+1], byte_log[b0+2]);
    end
    stretch_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n, cyc, b0, w0, s0, d0;
    present = 1'b1;
    wbytes[0] = 8'h5A;
    wbytes[1] = 8'hC3;
    @(negedge clk);
    dev_addr = 7'h3C;
    rw = 1'b0;
    len = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (wr_req !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL rs_wr_req_timeout got %0d want <5000", n);
    end
    repeat (5) @(negedge clk);
    s0 = n_stop;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({scl_oe, sda_oe, busy, done, wr_req,
         rd_valid, nack} !== 7'b0) begin
      errors++;
      $display("FAIL rs_ctl got %b want 0",
        {scl_oe, sda_oe, busy, done, wr_req, rd_valid, nack});
    end
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (n_stop - s0 !== 0) begin
      errors++;
      $display("FAIL rs_no_stop got %0d want 0", n_stop - s0);
    end
    wbytes[0] = 8'hA5;
    wbytes[1] = 8'h3C;
    b0 = byte_log.size();
    w0 = n_wr;
    d0 = n_done;
    dev_addr = 7'h3C;
    rw = 1'b0;
    len = 5'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 40) begin
        dev_addr = 7'h11;
        rw = 1'b1;
        len = 5'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (cyc !== 3596) begin
      errors++;
      $display("FAIL rs_cycles got %0d want 3596", cyc);
    end
    checks++;
    if (n_wr - w0 !== 2) begin
      errors++;
      $display("FAIL rs_wr_req got %0d want 2", n_wr - w0);
    end
    checks++;
    if (byte_log.size() - b0 !== 3) begin
      errors++;
      $display("FAIL rs_nbytes got %0d want 3",
        byte_log.size() - b0);
    end else if ({byte_log[b0], byte_log[b0+1],
                  byte_log[b0+2]} !== 24'h78A53C) begin
      errors++;
      $display("FAIL rs_bus got %h%h%h want 78a53c",
        byte_log[b0], byte_log[b0+1], byte_log[b0+2]);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_done - d0 !== 1) begin
      errors++;
      $display("FAIL rs_ignored got %b/%0d want 0/1",
        busy, n_done - d0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_probe();
    test_wr_nack();
    test_stretch();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
